// File: rtl/local_inject_arbiter_if.sv
// Handshake bundle between the PE injectors, the arbiter and the router Local port.
// The slave modport is the arbiter's view; the master modport is the view of the
// surrounding requesters and router that drive the arbiter.
interface local_inject_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int PTR_W     = 2,
  parameter int dataWidth = 32,
  parameter int CNT_W     = 16
);

  logic [NUM_REQ-1:0]           ReqUpStr;
  logic [NUM_REQ*dataWidth-1:0] PacketIn;
  logic [NUM_REQ-1:0]           GntUpStr;
  logic                         ReqDnStr;
  logic                         GntDnStr;
  logic                         DnStrFull;
  logic [dataWidth-1:0]         PacketOut;
  logic [PTR_W-1:0]             Winner;
  logic                         Busy;
  logic [CNT_W-1:0]             GrantCount;

  modport slave (
    input  ReqUpStr, PacketIn, GntDnStr, DnStrFull,
    output GntUpStr, ReqDnStr, PacketOut, Winner, Busy, GrantCount
  );

  modport master (
    output ReqUpStr, PacketIn, GntDnStr, DnStrFull,
    input  GntUpStr, ReqDnStr, PacketOut, Winner, Busy, GrantCount
  );

endinterface

// File: rtl/local_inject_arbiter.sv
// Round-robin arbiter sharing one router Local input port among NUM_REQ injectors.
// A winner's flit is latched and presented to the router; once the router grants,
// the winner gets a single-cycle grant pulse and priority rotates past it.
module local_inject_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int PTR_W     = 2,
  parameter int dataWidth = 32,
  parameter int CNT_W     = 16
) (
  input logic                   clk,
  input logic                   reset,
  local_inject_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    RELEASE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     last_q, last_d;
  logic [PTR_W-1:0]     winner_q, winner_d;
  logic [dataWidth-1:0] packet_q, packet_d;
  logic                 reqDn_q, reqDn_d;
  logic [NUM_REQ-1:0]   gntUp_q, gntUp_d;
  logic [CNT_W-1:0]     grantCount_q, grantCount_d;

  logic                 found;
  logic [PTR_W-1:0]     pick;

  // Rotating priority search: start just after the last completed winner and take the first requester found
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    pick  = last_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!found && bus.ReqUpStr[idx]) begin
        found = 1'b1;
        pick  = PTR_W'(idx);
      end
    end
  end

  // Next-state and output decode; the winner's flit is frozen once the request to the router is up
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    winner_d     = winner_q;
    packet_d     = packet_q;
    reqDn_d      = reqDn_q;
    gntUp_d      = '0;
    grantCount_d = grantCount_q;
    case (state_q)
      IDLE: begin
        if (found && !bus.DnStrFull) begin
          winner_d = pick;
          packet_d = bus.PacketIn[int'(pick)*dataWidth +: dataWidth];
          reqDn_d  = 1'b1;
          state_d  = WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        if (bus.GntDnStr) begin
          reqDn_d = 1'b0;
          for (int i = 0; i < NUM_REQ; i++) begin
            gntUp_d[i] = (winner_q == PTR_W'(i));
          end
          last_d       = winner_q;
          grantCount_d = grantCount_q + CNT_W'(1);
          state_d      = RELEASE;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops the router request and discards the latched flit at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_q       <= PTR_W'(NUM_REQ - 1);
      winner_q     <= PTR_W'(NUM_REQ - 1);
      packet_q     <= '0;
      reqDn_q      <= 1'b0;
      gntUp_q      <= '0;
      grantCount_q <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      winner_q     <= winner_d;
      packet_q     <= packet_d;
      reqDn_q      <= reqDn_d;
      gntUp_q      <= gntUp_d;
      grantCount_q <= grantCount_d;
    end
  end

  assign bus.GntUpStr   = gntUp_q;
  assign bus.ReqDnStr   = reqDn_q;
  assign bus.PacketOut  = packet_q;
  assign bus.Winner     = winner_q;
  assign bus.GrantCount = grantCount_q;
  assign bus.Busy       = (state_q != IDLE);

endmodule

// File: tb/tb_local_inject_arbiter.sv
// Directed and randomized checks of local_inject_arbiter against a transaction-level
// model that tracks only the last granted requester and the number of completed transfers.
module tb_local_inject_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int PTR_W     = 2;
  localparam int dataWidth = 32;
  localparam int CNT_W     = 16;

  logic clk;
  logic reset;

  int compCount;
  int errCount;

  int               mLast;
  logic [CNT_W-1:0] mCount;

  local_inject_arbiter_if #(
    .NUM_REQ(NUM_REQ), .PTR_W(PTR_W), .dataWidth(dataWidth), .CNT_W(CNT_W)
  ) bus ();

  local_inject_arbiter #(
    .NUM_REQ(NUM_REQ), .PTR_W(PTR_W), .dataWidth(dataWidth), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Spec rule: first set request bit searching last+1, last+2, ... modulo NUM_REQ
  function automatic int mPick(input logic [NUM_REQ-1:0] req, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (req[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compCount++;
    assert (observed === expected)
    else begin
      errCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One complete transfer: arbitration, router wait, grant pulse, release back to idle
  task automatic applyStimulus(input string tag, input logic [NUM_REQ-1:0] req,
                               input logic [NUM_REQ-1:0] waitReq, input int gntDelay,
                               input logic [NUM_REQ*dataWidth-1:0] pkts);
    int w;
    logic [31:0] expPkt;
    w = mPick(req, mLast);
    if (w < 0) w = 0;
    expPkt = pkts[w*dataWidth +: dataWidth];
    bus.ReqUpStr  = req;
    bus.PacketIn  = pkts;
    bus.DnStrFull = 1'b0;
    bus.GntDnStr  = 1'b0;
    tick();
    checkOutput({tag, ".reqDn"},  32'(bus.ReqDnStr),  32'd1);
    checkOutput({tag, ".winner"}, 32'(bus.Winner),    32'(w));
    checkOutput({tag, ".packet"}, bus.PacketOut,      expPkt);
    checkOutput({tag, ".busy"},   32'(bus.Busy),      32'd1);
    for (int i = 0; i < gntDelay; i++) begin
      bus.ReqUpStr  = waitReq;
      bus.PacketIn  = {$urandom, $urandom, $urandom, $urandom};
      bus.DnStrFull = 1'($urandom_range(0, 1));
      tick();
      checkOutput({tag, ".holdReq"}, 32'(bus.ReqDnStr), 32'd1);
      checkOutput({tag, ".holdPkt"}, bus.PacketOut,     expPkt);
      checkOutput({tag, ".noGnt"},   32'(bus.GntUpStr), 32'd0);
    end
    bus.ReqUpStr = waitReq;
    bus.GntDnStr = 1'b1;
    tick();
    mLast  = w;
    mCount = mCount + 1'b1;
    checkOutput({tag, ".gntUp"}, 32'(bus.GntUpStr),   32'(1) << w);
    checkOutput({tag, ".reqLo"}, 32'(bus.ReqDnStr),   32'd0);
    checkOutput({tag, ".count"}, 32'(bus.GrantCount), 32'(mCount));
    bus.GntDnStr  = 1'b0;
    bus.DnStrFull = 1'b0;
    bus.ReqUpStr  = waitReq & ~(NUM_REQ'(1) << w);
    tick();
    checkOutput({tag, ".gntPulse"}, 32'(bus.GntUpStr), 32'd0);
    checkOutput({tag, ".idle"},     32'(bus.Busy),     32'd0);
    checkOutput({tag, ".winHeld"},  32'(bus.Winner),   32'(w));
  endtask

  // Directed scenarios followed by a randomized run
  initial begin
    logic [NUM_REQ-1:0] rq;
    compCount = 0;
    errCount  = 0;
    mLast     = NUM_REQ - 1;
    mCount    = '0;
    reset         = 1'b1;
    bus.ReqUpStr  = '0;
    bus.PacketIn  = '0;
    bus.GntDnStr  = 1'b0;
    bus.DnStrFull = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    $display("[TB] reset values");
    checkOutput("rst.reqDn",  32'(bus.ReqDnStr),   32'd0);
    checkOutput("rst.gntUp",  32'(bus.GntUpStr),   32'd0);
    checkOutput("rst.packet", bus.PacketOut,       32'd0);
    checkOutput("rst.winner", 32'(bus.Winner),     32'(NUM_REQ - 1));
    checkOutput("rst.count",  32'(bus.GrantCount), 32'd0);
    checkOutput("rst.busy",   32'(bus.Busy),       32'd0);

    $display("[TB] single requester");
    applyStimulus("single", 4'b0001, 4'b0001, 1, {96'h0, 32'hA5A5_0001});
    checkOutput("single.pkt", bus.PacketOut, 32'hA5A5_0001);

    $display("[TB] round robin with all requesting");
    @(posedge clk); #1 reset = 1'b1;
    tick(); reset = 1'b0;
    mLast = NUM_REQ - 1; mCount = '0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus("rr", 4'b1111, 4'b1111, 0, {$urandom, $urandom, $urandom, $urandom});
      checkOutput("rr.order", 32'(bus.Winner), 32'(i % NUM_REQ));
    end
    checkOutput("rr.total", 32'(bus.GrantCount), 32'd5);

    $display("[TB] downstream full holds arbitration");
    bus.ReqUpStr  = 4'b0100;
    bus.DnStrFull = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("full.reqDn", 32'(bus.ReqDnStr), 32'd0);
      checkOutput("full.busy",  32'(bus.Busy),     32'd0);
    end
    applyStimulus("fullRel", 4'b0100, 4'b0000, 0, {$urandom, $urandom, $urandom, $urandom});
    checkOutput("fullRel.w2", 32'(bus.Winner), 32'd2);

    $display("[TB] withdrawal during wait");
    applyStimulus("withdraw", 4'b0010, 4'b1000, 2, {$urandom, $urandom, $urandom, $urandom});
    checkOutput("withdraw.w1", 32'(bus.Winner), 32'd1);
    applyStimulus("next", 4'b1000, 4'b1000, 0, {$urandom, $urandom, $urandom, $urandom});
    checkOutput("next.w3", 32'(bus.Winner), 32'd3);

    $display("[TB] asynchronous reset during wait");
    bus.ReqUpStr = 4'b0100;
    bus.PacketIn = {$urandom, $urandom, $urandom, $urandom};
    tick();
    checkOutput("arst.pre", 32'(bus.ReqDnStr), 32'd1);
    #1 reset = 1'b1;
    #1;
    checkOutput("arst.reqDn",  32'(bus.ReqDnStr), 32'd0);
    checkOutput("arst.packet", bus.PacketOut,     32'd0);
    checkOutput("arst.busy",   32'(bus.Busy),     32'd0);
    checkOutput("arst.winner", 32'(bus.Winner),   32'(NUM_REQ - 1));
    mLast = NUM_REQ - 1; mCount = '0;
    tick(); reset = 1'b0;
    applyStimulus("postRst", 4'b1001, 4'b1001, 1, {$urandom, $urandom, $urandom, $urandom});
    checkOutput("postRst.w0", 32'(bus.Winner), 32'd0);

    $display("[TB] grant counter wrap and stray grants");
    bus.ReqUpStr = '0;
    force dut.grantCount_q = 16'hFFFF;
    tick();
    release dut.grantCount_q;
    mCount = 16'hFFFF;
    tick();
    checkOutput("wrap.preload", 32'(bus.GrantCount), 32'h0000_FFFF);
    applyStimulus("wrap", 4'b0010, 4'b0000, 0, {$urandom, $urandom, $urandom, $urandom});
    checkOutput("wrap.zero", 32'(bus.GrantCount), 32'd0);
    bus.ReqUpStr = '0;
    bus.GntDnStr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stray.gntUp", 32'(bus.GntUpStr),   32'd0);
      checkOutput("stray.count", 32'(bus.GrantCount), 32'(mCount));
      checkOutput("stray.reqDn", 32'(bus.ReqDnStr),   32'd0);
    end
    bus.GntDnStr = 1'b0;

    $display("[TB] randomized transfers");
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.ReqUpStr  = NUM_REQ'($urandom_range(1, 15));
        bus.DnStrFull = 1'b1;
        tick();
        checkOutput("rnd.fullHold", 32'(bus.ReqDnStr), 32'd0);
        bus.DnStrFull = 1'b0;
      end
      rq = NUM_REQ'($urandom_range(1, 15));
      applyStimulus("rnd", rq, NUM_REQ'($urandom_range(0, 15)), $urandom_range(0, 3),
                    {$urandom, $urandom, $urandom, $urandom});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
    $finish;
  end

endmodule

// File: doc/local_inject_arbiter.md
Name: local_inject_arbiter

Overview:
- Round-robin arbiter that shares one router Local input port among NUM_REQ packet injectors (PEs).
- Each requester uses the same Req/Gnt handshake that a single injector uses toward the router. The arbiter forwards the winner's flit on ReqDnStr/PacketOut.
- When the router grants, the arbiter returns a one-cycle grant pulse to the winning requester.
- Sits between the PE injectors and the Local port FIFO of one mesh router.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- PTR_W, 2, width of the winner index; must equal ceil(log2(NUM_REQ)).
- dataWidth, 32, flit width in bits.
- CNT_W, 16, width of the grant counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- ReqUpStr  in  NUM_REQ  per-requester request; bit i belongs to requester i.
- PacketIn  in  NUM_REQ*dataWidth  flattened flits; requester i occupies [i*dataWidth +: dataWidth].
- GntUpStr  out  NUM_REQ  one-hot, one-cycle grant pulse back to the winning requester.
- ReqDnStr  out  1  request to the router Local port.
- GntDnStr  in  1  grant from the router Local port.
- DnStrFull  in  1  Local port FIFO full indicator.
- PacketOut  out  dataWidth  registered flit of the current winner.
- Winner  out  PTR_W  index of the last or current winner.
- Busy  out  1  high whenever state is not IDLE.
- GrantCount  out  CNT_W  total completed transfers; wraps modulo 2^CNT_W.

Behaviour:
- Reset values, applied immediately when reset is asserted:
  - ReqDnStr=0, GntUpStr=0, PacketOut=0, Winner=NUM_REQ-1, GrantCount=0, Busy=0.
  - state=IDLE, internal last-winner pointer=NUM_REQ-1.
- State IDLE:
  - If |ReqUpStr and !DnStrFull at a rising edge: select the winner by searching indices last+1, last+2, ... modulo NUM_REQ; the first set bit wins.
  - In the same edge: PacketOut<=PacketIn[winner], Winner<=winner, ReqDnStr<=1, state<=WAIT_GNT.
  - Latency from request sampled to ReqDnStr high is one cycle.
  - If DnStrFull=1, or no request is present, remain in IDLE with all outputs held.
- State WAIT_GNT:
  - ReqDnStr and PacketOut are held stable.
  - ReqUpStr and PacketIn changes are ignored, including withdrawal by the winner.
  - DnStrFull is ignored, because the router owns flow control once a request is up.
  - On GntDnStr=1: ReqDnStr<=0, GntUpStr[Winner]<=1, last<=Winner, GrantCount<=GrantCount+1, state<=RELEASE.
  - There is no timeout; the arbiter waits indefinitely.
- State RELEASE (exactly one cycle):
  - GntUpStr<=0, state<=IDLE.
  - The requester drops its request on the edge where it samples the grant, so its bit is already low when IDLE next evaluates. The bit is not re-granted unless the requester re-asserts.
- The next arbitration can occur on the edge after RELEASE. Minimum throughput is one flit per 3 cycles plus router grant latency.
- Fairness:
  - A requester that is continuously asserted is granted within NUM_REQ transfers.
  - Priority rotates only after a completed transfer, not on an abort or reset.
- GntDnStr=1 while in IDLE or RELEASE is ignored. No outputs change and no count is taken.
- GntUpStr is never multi-hot and is never high for more than one cycle.
- Busy = (state != IDLE), driven combinationally from the state register.
- Reset during WAIT_GNT: ReqDnStr drops immediately and the latched flit is discarded. After release of reset, requester 0 has priority.
- GrantCount overflow: 2^CNT_W-1 + 1 wraps to 0 with no flag.

Test Plan:
- Reset, then ReqUpStr=4'b0001, PacketIn[0]=32'hA5A5_0001, router grants 2 cycles after ReqDnStr rises -> ReqDnStr high 1 cycle after the request. PacketOut=32'hA5A5_0001, Winner=0. GntUpStr=4'b0001 for exactly one cycle. GrantCount=1.
- All four requesters held high with re-assert after each grant, router granting immediately -> grant order 0,1,2,3,0. GntUpStr is one-hot every time and GrantCount=5.
- ReqUpStr=4'b0100 with DnStrFull=1 for 10 cycles, then 0 -> ReqDnStr stays 0 and Busy stays 0 while full. ReqDnStr rises 1 cycle after DnStrFull falls, with Winner=2.
- In WAIT_GNT with Winner=1, requester 1 drops its request and requester 3 raises its own, then GntDnStr arrives -> the flit from requester 1 is completed and GntUpStr=4'b0010. Requester 3 wins the next arbitration.
- Assert reset mid-WAIT_GNT -> ReqDnStr=0, PacketOut=0 and Busy=0 immediately, without waiting for a clock edge. With ReqUpStr=4'b1001 after release, requester 0 wins first.
- Preload GrantCount to 16'hFFFF (force), then complete one transfer -> GrantCount=16'h0000. Also drive GntDnStr=1 in IDLE -> no GntUpStr pulse and no count change.
